scan_scheduler: RTL and testbench
=================================

Name: scan_scheduler

Overview:
Sequencing controller for the SCAN polar decoder datapath built from PE_bottom butterflies (f1/f2 L and R message updates). For code length N=2^M and P parallel PEs, it emits one PE-group operation descriptor per accepted cycle, in SCAN order: L-sweep, leaf decision, R-sweep, per phase, over a programmable number of iterations. It sits between the top-level decoder control and the LLR/R memory plus PE array.

Parameters:
M, 3, log2 of code length N
LOG2P, 1, log2 of PE count P; requires LOG2P <= M-1
PIPE_LAT, 0, datapath write-back latency in cycles; drain inserted after each stage-step
ITW, 4, width of iteration count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin decode; sampled only in IDLE
num_iter  in  ITW  iteration count, latched at start; 0 treated as 1
busy  out  1  high from the cycle after accepted start until done
done  out  1  one-cycle pulse at end of decode
op_valid  out  1  descriptor valid
op_ready  in  1  datapath accepts descriptor
op_dir  out  1  0 = L update (f toward leaves), 1 = R update (toward channel)
op_stage  out  clog2(M)  butterfly stage; 0 = leaf side, M-1 = channel side
op_group  out  M-1-LOG2P  PE group within stage; N/(2P) groups
op_phase  out  M  current phase phi
last_iter  out  1  high during final iteration
leaf_valid  out  1  one-cycle leaf-decision pulse
leaf_phase  out  M  phi for leaf_valid

Behaviour:
- Reset: all outputs 0; FSM IDLE; all counters 0. Reset mid-decode aborts immediately with no done pulse.
- States: IDLE, LSWEEP, LEAF, RSWEEP, DRAIN, FIN.
- IDLE: start=1 latches num_iter and sets phi=0, iter=0; enters LSWEEP next cycle. start is ignored while busy.
- L-sweep for phi: k = M if phi==0, else ctz(phi)+1. Stages run k-1 down to 0.
- Stage-step: groups 0..N/(2P)-1 in order. Descriptor is held stable while op_valid=1 and op_ready=0. Advance happens only on op_valid && op_ready.
- After the last group of each stage-step: DRAIN for PIPE_LAT cycles (skipped if 0), op_valid=0, then the next stage-step or LEAF.
- LEAF: exactly one cycle, leaf_valid=1, leaf_phase=phi. No handshake and no drain.
- R-sweep: runs only if phi is odd. Stages run 0 up to min(cto(phi),M)-1, where cto = count of trailing ones. Same group, handshake and drain rules as L-sweep.
- Phase advance: phi increments after the R-sweep, or after LEAF if phi is even.
- Iteration wrap: phi wraps N-1 -> 0 and iter increments. When iter reaches num_iter: FIN, done=1 for one cycle, busy=0 in that same cycle, then IDLE.
- last_iter = busy && (iter == num_iter_latched-1).
- Stage, group and phase counters are unsigned and wrap-free by construction. op_stage never exceeds M-1.
- op_ready held low stalls indefinitely with no timeout. op_ready is ignored when op_valid=0.

Decomposition:
- Shared package scan_pkg: M, N, P, stage/group/phase widths, op_dir encoding, clog2 function.
- Sub-module scan_phase_ctl: combinational ctz/cto of phi giving L start stage and R stage count.
- FSM and counters stay in scan_scheduler.

Test Plan:
- M=3, LOG2P=1, PIPE_LAT=0, op_ready=1, num_iter=1, start at cycle 0.
  - Ops on cycles 1..50: 42 ops and 8 leaf pulses.
  - Phase 0 emits L stages 2,1,0 (groups 0,1 each), then leaf.
  - done at cycle 51.
- Same config, check phi=7 sequence: L stage 0 g0,g1; leaf; R stages 0,1,2 with g0,g1 each.
- PIPE_LAT=2, num_iter=1: 21 stage-steps, each followed by 2 idle cycles; done at cycle 93.
- num_iter=3: last_iter low for the first 100 op/leaf cycles and high for the last 50; exactly one done pulse.
- Random op_ready with ~50% low: descriptor stable across stalls; same op sequence as the ready=1 run; leaf pulses unaffected.
- rst_n asserted mid-RSWEEP: outputs 0 at once. start=1 with num_iter=0 afterwards: runs one iteration, done once.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared constants, state encodings and width helpers for the SCAN decoder scheduler.
package scan_pkg;

  // Default decoder geometry: N = 2^M code bits, P = 2^LOG2P butterfly PEs.
  localparam int SCAN_M        = 3;
  localparam int SCAN_LOG2P    = 1;
  localparam int SCAN_PIPE_LAT = 0;
  localparam int SCAN_ITW      = 4;
  localparam int SCAN_N        = 1 << SCAN_M;
  localparam int SCAN_P        = 1 << SCAN_LOG2P;

  // op_dir encoding.
  localparam logic OP_DIR_L = 1'b0;  // f-update toward the leaves
  localparam logic OP_DIR_R = 1'b1;  // g-update toward the channel

  // Scheduler FSM states.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LSWEEP = 3'd1;
  localparam logic [2:0] ST_LEAF   = 3'd2;
  localparam logic [2:0] ST_RSWEEP = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_FIN    = 3'd5;

  // Ceiling log2 for elaboration-time width arithmetic.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Width of a field holding values 0..v-1, never narrower than one bit.
  function automatic int wbits(input int v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

  // Width of the PE-group index: N/(2P) groups, at least one bit wide.
  function automatic int grp_w(input int m, input int log2p);
    return ((m - 1 - log2p) < 1) ? 1 : (m - 1 - log2p);
  endfunction

endpackage

// File: rtl/scan_phase_ctl.sv
// Per-phase sweep bounds: L-sweep start stage of the following phase (ctz based)
// and last R-sweep stage of the current phase (cto based).
module scan_phase_ctl
  import scan_pkg::*;
#(
  parameter int M  = SCAN_M,
  parameter int SW = wbits(SCAN_M)
) (
  input  logic [M-1:0]  phi_i,
  output logic [SW-1:0] next_l_top_o,
  output logic [SW-1:0] r_last_o
);

  logic [M-1:0] phi_nxt;

  assign phi_nxt = phi_i + M'(1);

  // L start stage for phi+1 is ctz(phi+1); phase 0 (after the wrap) starts at M-1.
  always_comb begin
    next_l_top_o = SW'(M - 1);
    for (int i = M - 1; i >= 0; i--) begin
      if (phi_nxt[i]) next_l_top_o = SW'(i);
    end
  end

  // Last R stage is cto(phi)-1; all-ones phi runs every stage. Even phi has no R-sweep.
  always_comb begin
    r_last_o = SW'(M - 1);
    for (int i = M - 1; i >= 1; i--) begin
      if (!phi_i[i]) r_last_o = SW'(i - 1);
    end
    if (!phi_i[0]) r_last_o = '0;
  end

endmodule

// File: rtl/scan_scheduler.sv
// SCAN polar decoder sequencer: walks L-sweep, leaf decision and R-sweep for every
// phase over the programmed iteration count, issuing one PE-group descriptor per
// accepted handshake and draining the datapath after each stage-step.
module scan_scheduler
  import scan_pkg::*;
#(
  parameter int M        = SCAN_M,
  parameter int LOG2P    = SCAN_LOG2P,
  parameter int PIPE_LAT = SCAN_PIPE_LAT,
  parameter int ITW      = SCAN_ITW
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [ITW-1:0]                num_iter,
  output logic                          busy,
  output logic                          done,
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic                          op_dir,
  output logic [wbits(M)-1:0]           op_stage,
  output logic [grp_w(M, LOG2P)-1:0]    op_group,
  output logic [M-1:0]                  op_phase,
  output logic                          last_iter,
  output logic                          leaf_valid,
  output logic [M-1:0]                  leaf_phase
);

  localparam int N    = 1 << M;
  localparam int SW   = wbits(M);
  localparam int GW   = grp_w(M, LOG2P);
  localparam int NGRP = 1 << (M - 1 - LOG2P);
  localparam int DW   = clog2(PIPE_LAT + 2);

  logic [2:0]     state_q, state_d;
  logic [2:0]     ret_q, ret_d;
  logic [M-1:0]   phi_q, phi_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic [ITW-1:0] niter_q, niter_d;
  logic [SW-1:0]  stage_q, stage_d;
  logic [GW-1:0]  group_q, group_d;
  logic [DW-1:0]  dcnt_q, dcnt_d;

  logic [SW-1:0]  next_l_top;
  logic [SW-1:0]  r_last;
  logic [M-1:0]   phi_nxt;
  logic [2:0]     step_nxt;
  logic [2:0]     adv_state;
  logic [M-1:0]   adv_phi;
  logic [ITW-1:0] adv_iter;

  assign phi_nxt = phi_q + M'(1);

  scan_phase_ctl #(
    .M  (M),
    .SW (SW)
  ) u_phase_ctl (
    .phi_i        (phi_q),
    .next_l_top_o (next_l_top),
    .r_last_o     (r_last)
  );

  // Phase-advance target: next phi, or wrap into the next iteration / finish.
  always_comb begin
    adv_state = ST_LSWEEP;
    adv_phi   = phi_nxt;
    adv_iter  = iter_q;
    if (phi_q == M'(N - 1)) begin
      adv_iter = iter_q + ITW'(1);
      if (({1'b0, iter_q} + (ITW + 1)'(1)) >= {1'b0, niter_q}) adv_state = ST_FIN;
    end
  end

  // Next-state and counter update for the SCAN schedule.
  always_comb begin
    state_d  = state_q;
    ret_d    = ret_q;
    phi_d    = phi_q;
    iter_d   = iter_q;
    niter_d  = niter_q;
    stage_d  = stage_q;
    group_d  = group_q;
    dcnt_d   = dcnt_q;
    step_nxt = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          niter_d = (num_iter == '0) ? ITW'(1) : num_iter;
          phi_d   = '0;
          iter_d  = '0;
          stage_d = SW'(M - 1);
          group_d = '0;
          state_d = ST_LSWEEP;
        end
      end
      ST_LSWEEP, ST_RSWEEP: begin
        if (op_ready) begin
          if (group_q != GW'(NGRP - 1)) begin
            group_d = group_q + GW'(1);
          end else begin
            group_d = '0;
            if (state_q == ST_LSWEEP) begin
              if (stage_q != '0) begin
                step_nxt = ST_LSWEEP;
                stage_d  = stage_q - SW'(1);
              end else begin
                step_nxt = ST_LEAF;
              end
            end else begin
              if (stage_q != r_last) begin
                step_nxt = ST_RSWEEP;
                stage_d  = stage_q + SW'(1);
              end else begin
                step_nxt = adv_state;
                phi_d    = adv_phi;
                iter_d   = adv_iter;
                stage_d  = next_l_top;
              end
            end
            // Stage-step complete: let the datapath write back before the next one.
            if (PIPE_LAT == 0) begin
              state_d = step_nxt;
            end else begin
              state_d = ST_DRAIN;
              ret_d   = step_nxt;
              dcnt_d  = DW'(PIPE_LAT - 1);
            end
          end
        end
      end
      ST_LEAF: begin
        if (phi_q[0]) begin
          state_d = ST_RSWEEP;
          stage_d = '0;
        end else begin
          state_d = adv_state;
          phi_d   = adv_phi;
          iter_d  = adv_iter;
          stage_d = next_l_top;
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == '0) state_d = ret_q;
        else              dcnt_d  = dcnt_q - DW'(1);
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers; reset aborts any decode in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ret_q   <= ST_IDLE;
      phi_q   <= '0;
      iter_q  <= '0;
      niter_q <= '0;
      stage_q <= '0;
      group_q <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      phi_q   <= phi_d;
      iter_q  <= iter_d;
      niter_q <= niter_d;
      stage_q <= stage_d;
      group_q <= group_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Outputs decoded straight from state so reset clears them immediately.
  always_comb begin
    busy       = (state_q != ST_IDLE) && (state_q != ST_FIN);
    done       = (state_q == ST_FIN);
    op_valid   = (state_q == ST_LSWEEP) || (state_q == ST_RSWEEP);
    op_dir     = (state_q == ST_RSWEEP) ? OP_DIR_R : OP_DIR_L;
    op_stage   = op_valid ? stage_q : '0;
    op_group   = op_valid ? group_q : '0;
    op_phase   = phi_q;
    leaf_valid = (state_q == ST_LEAF);
    leaf_phase = leaf_valid ? phi_q : '0;
    last_iter  = busy && (iter_q == (niter_q - ITW'(1)));
  end

endmodule

// File: tb/tb_scan_scheduler.sv
// Directed bench for scan_scheduler with a scoreboard of expected SCAN descriptors.
module tb_scan_scheduler;
  import scan_pkg::*;

  localparam int M   = 3;
  localparam int N   = 1 << M;
  localparam int ITW = 4;
  localparam int NG  = 2;
  localparam int SW  = wbits(M);
  localparam int GW  = grp_w(M, 1);

  typedef struct {
    bit leaf;
    bit dir;
    int stage;
    int grp;
    int phase;
    bit last;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [ITW-1:0] num_iter;
  logic           op_ready;
  logic           sel;

  logic           busy0, done0, valid0, dir0, last0, leaf0;
  logic [SW-1:0]  stage0;
  logic [GW-1:0]  group0;
  logic [M-1:0]   phase0, lphase0;
  logic           busy2, done2, valid2, dir2, last2, leaf2;
  logic [SW-1:0]  stage2;
  logic [GW-1:0]  group2;
  logic [M-1:0]   phase2, lphase2;

  logic           o_busy, o_done, o_valid, o_dir, o_last, o_leaf;
  logic [SW-1:0]  o_stage;
  logic [GW-1:0]  o_group;
  logic [M-1:0]   o_phase, o_lphase;

  exp_t exp_q[$];
  int   rec0[$];
  int   rec7[$];
  bit   rec_en;
  bit   found;
  int   n_cmp;
  int   n_err;

  scan_scheduler #(.M(M), .LOG2P(1), .PIPE_LAT(0), .ITW(ITW)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_iter(num_iter),
    .busy(busy0), .done(done0), .op_valid(valid0), .op_ready(op_ready),
    .op_dir(dir0), .op_stage(stage0), .op_group(group0), .op_phase(phase0),
    .last_iter(last0), .leaf_valid(leaf0), .leaf_phase(lphase0)
  );

  scan_scheduler #(.M(M), .LOG2P(1), .PIPE_LAT(2), .ITW(ITW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_iter(num_iter),
    .busy(busy2), .done(done2), .op_valid(valid2), .op_ready(op_ready),
    .op_dir(dir2), .op_stage(stage2), .op_group(group2), .op_phase(phase2),
    .last_iter(last2), .leaf_valid(leaf2), .leaf_phase(lphase2)
  );

  assign o_busy   = sel ? busy2   : busy0;
  assign o_done   = sel ? done2   : done0;
  assign o_valid  = sel ? valid2  : valid0;
  assign o_dir    = sel ? dir2    : dir0;
  assign o_last   = sel ? last2   : last0;
  assign o_leaf   = sel ? leaf2   : leaf0;
  assign o_stage  = sel ? stage2  : stage0;
  assign o_group  = sel ? group2  : group0;
  assign o_phase  = sel ? phase2  : phase0;
  assign o_lphase = sel ? lphase2 : lphase0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic chk_zero();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_op_valid", o_valid, 0);
    chk("rst_op_dir", o_dir, 0);
    chk("rst_op_stage", o_stage, 0);
    chk("rst_op_group", o_group, 0);
    chk("rst_op_phase", o_phase, 0);
    chk("rst_last_iter", o_last, 0);
    chk("rst_leaf_valid", o_leaf, 0);
    chk("rst_leaf_phase", o_lphase, 0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    op_ready = 1'b0;
    num_iter = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic void push(input bit leaf, input bit dir, input int stage,
                               input int grp, input int phase, input bit last);
    exp_t e;
    e.leaf = leaf; e.dir = dir; e.stage = stage;
    e.grp = grp; e.phase = phase; e.last = last;
    exp_q.push_back(e);
  endfunction

  // Reference SCAN order: L stages k-1..0, leaf, then R stages 0..cto-1 for odd phi.
  function automatic void build(input int niter);
    exp_q.delete();
    for (int it = 0; it < niter; it++) begin
      for (int phi = 0; phi < N; phi++) begin
        int  k;
        int  c;
        bit  lst;
        lst = (it == niter - 1);
        if (phi == 0) k = M;
        else begin
          c = 0;
          while (((phi >> c) & 1) == 0) c++;
          k = c + 1;
        end
        for (int s = k - 1; s >= 0; s--)
          for (int g = 0; g < NG; g++) push(1'b0, 1'b0, s, g, phi, lst);
        push(1'b1, 1'b0, 0, 0, phi, lst);
        if (phi % 2 == 1) begin
          c = 0;
          while (c < M && ((phi >> c) & 1) == 1) c++;
          for (int s = 0; s < c; s++)
            for (int g = 0; g < NG; g++) push(1'b0, 1'b1, s, g, phi, lst);
        end
      end
    end
  endfunction

  task automatic decode(input int niter, input bit stall, input int exp_done,
                        input int exp_idle, input int exp_lastn);
    int   cyc;
    int   done_cyc;
    int   n_done;
    int   n_idle;
    int   n_last;
    int   post;
    int   code;
    int   ph;
    exp_t e;
    done_cyc = -1; n_done = 0; n_idle = 0; n_last = 0; post = 0;
    build((niter == 0) ? 1 : niter);
    @(negedge clk);
    start    = 1'b1;
    num_iter = ITW'(niter);
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc   = 1;
    while (cyc < 3000 && post < 4) begin
      op_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o_leaf || o_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_output", {30'd0, o_leaf, o_valid}, 0);
        end else begin
          e = exp_q[0];
          chk("is_leaf", o_leaf, e.leaf);
          if (e.leaf) begin
            chk("leaf_phase", o_lphase, e.phase);
          end else begin
            chk("op_dir", o_dir, e.dir);
            chk("op_stage", o_stage, e.stage);
            chk("op_group", o_group, e.grp);
            chk("op_phase", o_phase, e.phase);
          end
          chk("last_iter", o_last, e.last);
          chk("busy_active", o_busy, 1);
          if (o_leaf || op_ready) begin
            if (o_last) n_last++;
            if (rec_en) begin
              code = o_leaf ? 999 : int'(o_dir) * 100 + int'(o_stage) * 10 + int'(o_group);
              ph   = o_leaf ? int'(o_lphase) : int'(o_phase);
              if (ph == 0) rec0.push_back(code);
              if (ph == 7) rec7.push_back(code);
            end
            void'(exp_q.pop_front());
          end
        end
      end else if (o_busy) begin
        n_idle++;
      end
      if (o_done) begin
        n_done++;
        done_cyc = cyc;
        chk("busy_at_done", o_busy, 0);
      end
      if (n_done > 0) post++;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_count", n_done, 1);
    chk("queue_drained", exp_q.size(), 0);
    if (exp_done >= 0) chk("done_cycle", done_cyc, exp_done);
    if (exp_idle >= 0) chk("idle_cycles", n_idle, exp_idle);
    if (exp_lastn >= 0) chk("last_iter_cycles", n_last, exp_lastn);
  endtask

  initial begin
    int exp0[7];
    int exp7[9];
    exp0 = '{20, 21, 10, 11, 0, 1, 999};
    exp7 = '{0, 1, 999, 100, 101, 110, 111, 120, 121};
    n_cmp  = 0;
    n_err  = 0;
    rec_en = 1'b0;
    found  = 1'b0;
    sel    = 1'b0;

    // Reset state of both instances.
    do_reset();
    sel = 1'b1;
    do_reset();

    // Baseline: one iteration, always ready, no drain.
    sel = 1'b0;
    do_reset();
    rec_en = 1'b1;
    decode(1, 1'b0, 51, 0, 50);
    rec_en = 1'b0;
    chk("phase0_len", rec0.size(), 7);
    for (int i = 0; i < rec0.size() && i < 7; i++) chk("phase0_seq", rec0[i], exp0[i]);
    chk("phase7_len", rec7.size(), 9);
    for (int i = 0; i < rec7.size() && i < 9; i++) chk("phase7_seq", rec7[i], exp7[i]);

    // Two-cycle write-back drain after each of the 21 stage-steps.
    sel = 1'b1;
    do_reset();
    decode(1, 1'b0, 93, 42, 50);

    // Three iterations: only the final 50 op/leaf cycles flag last_iter.
    sel = 1'b0;
    do_reset();
    decode(3, 1'b0, 151, 0, 50);

    // Random backpressure on op_ready.
    do_reset();
    decode(1, 1'b1, -1, -1, 50);

    // Abort in the middle of an R-sweep, then restart with num_iter = 0.
    do_reset();
    @(negedge clk);
    start    = 1'b1;
    num_iter = ITW'(1);
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (o_valid && o_dir) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("reach_rsweep", found, 1);
    rst_n = 1'b0;
    #1;
    chk_zero();
    @(negedge clk);
    rst_n = 1'b1;
    decode(0, 1'b0, 51, 0, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
